// File: rtl/rv32i_pkg.sv
// Shared RV32I decode helpers: opcode keys, the bubble instruction and
// register-field accessors used by the pipeline hazard logic.
package rv32i_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [4:0] get_opc(input logic [31:0] instr);
        return instr[6:2];
    endfunction

    function automatic logic [4:0] get_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] get_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] get_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic uses_rs1(input logic [31:0] instr);
        logic [4:0] opc;
        opc = get_opc(instr);
        return (opc != OP_LUI) && (opc != OP_AUIPC) && (opc != OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] instr);
        logic [4:0] opc;
        opc = get_opc(instr);
        return (opc == OP_R) || (opc == OP_STORE) || (opc == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector between the ID and EX stages; purely combinational
// so the stall reaches the PC and IF/ID registers in the same cycle.
module hazard_detect
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_id,
    input  logic        valid_id,
    input  logic [31:0] instr_ex,
    input  logic        valid_ex,
    input  logic        flush,
    output logic        hazard,
    output logic        stall
);

    logic       ex_is_load;
    logic [4:0] rd_ex;
    logic       rs1_match;
    logic       rs2_match;

    assign ex_is_load = valid_ex && (get_opc(instr_ex) == OP_LOAD);
    assign rd_ex      = get_rd(instr_ex);
    assign rs1_match  = uses_rs1(instr_id) && (get_rs1(instr_id) == rd_ex);
    assign rs2_match  = uses_rs2(instr_id) && (get_rs2(instr_id) == rd_ex);

    // x0 is hardwired to zero, so a load into it can never feed a consumer.
    assign hazard = valid_id && ex_is_load && (rd_ex != 5'd0) && (rs1_match || rs2_match);

    // A redirect makes the ID instruction wrong-path, so holding it is pointless.
    assign stall  = hazard && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, redirect flush and
// a saturating stall-cycle counter for performance monitoring.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN  = 32,
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_id,
    input  logic [XLEN-1:0]  pc_id,
    input  logic [XLEN-1:0]  rs1_data_id,
    input  logic [XLEN-1:0]  rs2_data_id,
    input  logic [XLEN-1:0]  imm_id,
    input  logic             valid_id,
    input  logic             flush,
    output logic [31:0]      instr_ex,
    output logic [XLEN-1:0]  pc_ex,
    output logic [XLEN-1:0]  rs1_data_ex,
    output logic [XLEN-1:0]  rs2_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic             valid_ex,
    output logic             stall_if,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0]      instr_q, instr_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;
    logic             stall;

    hazard_detect u_hazard_detect (
        .instr_id (instr_id),
        .valid_id (valid_id),
        .instr_ex (instr_q),
        .valid_ex (valid_q),
        .flush    (flush),
        .hazard   (hazard),
        .stall    (stall)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its current value first,
        // so no path through the branches below can infer a latch.
        instr_d = instr_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (flush || hazard) begin
            // Bubble: data fields keep their stale value, they are don't-care.
            instr_d = NOP;
            valid_d = 1'b0;
        end else begin
            instr_d = valid_id ? instr_id : NOP;
            pc_d    = pc_id;
            rs1_d   = rs1_data_id;
            rs2_d   = rs2_data_id;
            imm_d   = imm_id;
            valid_d = valid_id;
        end

        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_ex    = instr_q;
    assign pc_ex       = pc_q;
    assign rs1_data_ex = rs1_q;
    assign rs2_data_ex = rs2_q;
    assign imm_ex      = imm_q;
    assign valid_ex    = valid_q;
    assign stall_if    = stall;
    assign stall_id    = stall;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// saturation sequences, then random traffic against a behavioural model.
module tb_id_ex_stage;

    localparam logic [31:0] NOP_I = 32'h0000_0013;
    localparam logic [31:0] LW5   = 32'h0000_A283;
    localparam logic [31:0] ADD65 = 32'h0012_8333;
    localparam logic [31:0] SW5   = 32'h0051_2023;
    localparam logic [31:0] LUI6  = 32'h0002_8337;
    localparam logic [31:0] LW0   = 32'h0000_A003;
    localparam logic [31:0] ADD60 = 32'h0010_0333;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic [31:0] instr_id;
    logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
    logic        valid_id;
    logic        flush;

    logic [31:0] instr_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic        valid_ex, stall_if, stall_id;
    logic [15:0] stall_cnt;

    logic [31:0] instr_ex2, pc_ex2, rs1_data_ex2, rs2_data_ex2, imm_ex2;
    logic        valid_ex2, stall_if2, stall_id2;
    logic [1:0]  stall_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .instr_id(instr_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .valid_id(valid_id), .flush(flush),
        .instr_ex(instr_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .valid_ex(valid_ex),
        .stall_if(stall_if), .stall_id(stall_id), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst2_n),
        .instr_id(instr_id), .pc_id(pc_id), .rs1_data_id(rs1_data_id),
        .rs2_data_id(rs2_data_id), .imm_id(imm_id), .valid_id(valid_id), .flush(flush),
        .instr_ex(instr_ex2), .pc_ex(pc_ex2), .rs1_data_ex(rs1_data_ex2),
        .rs2_data_ex(rs2_data_ex2), .imm_ex(imm_ex2), .valid_ex(valid_ex2),
        .stall_if(stall_if2), .stall_id(stall_id2), .stall_cnt(stall_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model of the EX-side register contents.
    logic [31:0] m_instr, m_pc, m_rs1, m_rs2, m_imm;
    bit          m_valid;
    int          m_cnt, m_cnt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_instr = NOP_I;
        m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
        m_valid = 0;
        m_cnt = 0;
    endfunction

    // Load-use rule evaluated straight from the instruction fields.
    function automatic bit ref_hazard();
        int  op_id, op_ex, rd, r1, r2;
        bit  reads1, reads2;
        op_id  = int'(instr_id[6:2]);
        op_ex  = int'(m_instr[6:2]);
        rd     = int'(m_instr[11:7]);
        r1     = int'(instr_id[19:15]);
        r2     = int'(instr_id[24:20]);
        reads1 = !(op_id == 13 || op_id == 5 || op_id == 27);
        reads2 = (op_id == 12 || op_id == 8 || op_id == 24);
        if (!valid_id || !m_valid || op_ex != 0 || rd == 0) return 0;
        return (reads1 && r1 == rd) || (reads2 && r2 == rd);
    endfunction

    task automatic drive(input logic [31:0] instr, input bit valid, input bit fl);
        instr_id    = instr;
        valid_id    = valid;
        flush       = fl;
        pc_id       = $urandom;
        rs1_data_id = $urandom;
        rs2_data_id = $urandom;
        imm_id      = $urandom;
    endtask

    // One clock: stall checked mid-cycle, registers checked just after the edge.
    task automatic step(input int tab_stall);
        bit hz, st;
        @(negedge clk);
        hz = ref_hazard();
        st = hz && !flush;
        check("stall_if", {31'b0, stall_if}, {31'b0, st});
        check("stall_id", {31'b0, stall_id}, {31'b0, st});
        if (tab_stall >= 0) check("tab_stall", {31'b0, stall_id}, 32'(tab_stall));
        @(posedge clk);
        if (flush || hz) begin
            m_instr = NOP_I;
            m_valid = 0;
        end else begin
            m_instr = valid_id ? instr_id : NOP_I;
            m_valid = valid_id;
            m_pc = pc_id; m_rs1 = rs1_data_id; m_rs2 = rs2_data_id; m_imm = imm_id;
        end
        if (st && m_cnt < 65535) m_cnt++;
        if (!rst2_n) m_cnt2 = 0;
        else if (st && m_cnt2 < 3) m_cnt2++;
        #1;
        check("instr_ex", instr_ex, m_instr);
        check("valid_ex", {31'b0, valid_ex}, {31'b0, m_valid});
        check("pc_ex", pc_ex, m_pc);
        check("rs1_data_ex", rs1_data_ex, m_rs1);
        check("rs2_data_ex", rs2_data_ex, m_rs2);
        check("imm_ex", imm_ex, m_imm);
        check("stall_cnt", {16'b0, stall_cnt}, 32'(m_cnt));
        check("stall_cnt_sat", {30'b0, stall_cnt2}, 32'(m_cnt2));
    endtask

    typedef struct {
        logic [31:0] instr;
        bit          valid;
        bit          fl;
        int          exp_stall;
        logic [31:0] exp_instr;
        bit          exp_valid;
        int          exp_cnt;
    } vec_t;

    vec_t        vecs[16];
    int          sat_exp[5];
    logic [4:0]  opcs[9];

    initial begin
        vecs[0]  = '{LW5,   1, 0, 0, LW5,   1, 0};
        vecs[1]  = '{ADD65, 1, 0, 1, NOP_I, 0, 1};
        vecs[2]  = '{ADD65, 1, 0, 0, ADD65, 1, 1};
        vecs[3]  = '{LW5,   1, 0, 0, LW5,   1, 1};
        vecs[4]  = '{SW5,   1, 0, 1, NOP_I, 0, 2};
        vecs[5]  = '{SW5,   1, 0, 0, SW5,   1, 2};
        vecs[6]  = '{LW5,   1, 0, 0, LW5,   1, 2};
        vecs[7]  = '{LUI6,  1, 0, 0, LUI6,  1, 2};
        vecs[8]  = '{LW0,   1, 0, 0, LW0,   1, 2};
        vecs[9]  = '{ADD60, 1, 0, 0, ADD60, 1, 2};
        vecs[10] = '{LW5,   1, 0, 0, LW5,   1, 2};
        vecs[11] = '{ADD65, 1, 1, 0, NOP_I, 0, 2};
        vecs[12] = '{ADD65, 1, 0, 0, ADD65, 1, 2};
        vecs[13] = '{LW5,   0, 0, 0, NOP_I, 0, 2};
        vecs[14] = '{LW5,   1, 0, 0, LW5,   1, 2};
        vecs[15] = '{ADD65, 0, 0, 0, NOP_I, 0, 2};
        sat_exp  = '{1, 2, 3, 3, 3};
        opcs     = '{5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001,
                     5'b01101, 5'b00101, 5'b01100, 5'b00100};

        rst_n = 1'b0;
        rst2_n = 1'b0;
        drive(NOP_I, 0, 0);
        model_reset();
        m_cnt2 = 0;
        #12;
        check("rst_instr_ex", instr_ex, NOP_I);
        check("rst_valid_ex", {31'b0, valid_ex}, 32'd0);
        check("rst_pc_ex", pc_ex, 32'd0);
        check("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("rst_stall_id", {31'b0, stall_id}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].instr, vecs[i].valid, vecs[i].fl);
            step(vecs[i].exp_stall);
            check("tab_instr_ex", instr_ex, vecs[i].exp_instr);
            check("tab_valid_ex", {31'b0, valid_ex}, {31'b0, vecs[i].exp_valid});
            check("tab_stall_cnt", {16'b0, stall_cnt}, 32'(vecs[i].exp_cnt));
        end

        // Reset asserted between edges while a load-use stall is active.
        drive(LW5, 1, 0);
        step(0);
        drive(ADD65, 1, 0);
        @(negedge clk);
        check("pre_rst_stall", {31'b0, stall_id}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_stall_if", {31'b0, stall_if}, 32'd0);
        check("midrst_stall_id", {31'b0, stall_id}, 32'd0);
        check("midrst_instr_ex", instr_ex, NOP_I);
        check("midrst_valid_ex", {31'b0, valid_ex}, 32'd0);
        check("midrst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_instr_ex", instr_ex, NOP_I);
        check("rst_hold_stall_cnt", {16'b0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins        = $urandom;
            ins[1:0]   = 2'b11;
            ins[6:2]   = opcs[$urandom_range(0, 8)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive(ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15));
            step(-1);
        end

        // Saturation on the narrow-counter instance: counts 1,2,3,3,3.
        drive(NOP_I, 0, 0);
        step(-1);
        rst2_n = 1'b1;
        m_cnt2 = 0;
        for (int k = 0; k < 5; k++) begin
            drive(LW5, 1, 0);
            step(0);
            drive(ADD65, 1, 0);
            step(1);
            check("sat_cnt", {30'b0, stall_cnt2}, 32'(sat_exp[k]));
            drive(ADD65, 1, 0);
            step(0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core, with load-use hazard detection and control-hazard bubble insertion.
- Sits directly upstream of fwdunit and produces the instr_ex, pc_ex and operand values that fwdunit and the EX stage consume.
- Stalls IF/ID for one cycle on a load-use dependency and inserts NOP bubbles into EX on a stall or a redirect flush.
- Keeps a saturating hazard-stall counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width for pc, operand and immediate fields.
- CNT_W, 16, width of the saturating stall counter.
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous deassert in the reset tree.
- instr_id  in  32  decoded-stage instruction.
- pc_id  in  XLEN  PC of instr_id.
- rs1_data_id  in  XLEN  register-file read A.
- rs2_data_id  in  XLEN  register-file read B.
- imm_id  in  XLEN  sign-extended immediate.
- valid_id  in  1  instr_id is a real instruction.
- flush  in  1  EX-stage redirect (taken branch or jump).
- instr_ex  out  32  registered instruction to EX and fwdunit.
- pc_ex  out  XLEN  registered PC.
- rs1_data_ex  out  XLEN  registered operand A.
- rs2_data_ex  out  XLEN  registered operand B.
- imm_ex  out  XLEN  registered immediate.
- valid_ex  out  1  instr_ex is real; 0 marks a bubble.
- stall_if  out  1  hold PC register (combinational).
- stall_id  out  1  hold IF/ID register (combinational).
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst_n=0, async): instr_ex=NOP, pc_ex/rs1_data_ex/rs2_data_ex/imm_ex=0, valid_ex=0, stall_cnt=0. stall_if and stall_id evaluate to 0 because instr_ex=NOP is not a load.
- Field extraction: rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20], opcode key = instr[6:2].
- ex_is_load: valid_ex and instr_ex[6:2]==5'b00000.
- uses_rs1: every opcode except LUI 01101, AUIPC 00101, JAL 11011.
- uses_rs2: only R-type 01100, STORE 01000 and BRANCH 11000.
- hazard = valid_id & ex_is_load & (rd_ex != 0) & ((uses_rs1 & rs1_id==rd_ex) | (uses_rs2 & rs2_id==rd_ex)).
- stall_if = stall_id = hazard & ~flush. This is combinational, same cycle as the condition.
- Register update on each rising clk edge, in priority order:
  1. flush=1: load the bubble (instr_ex=NOP, valid_ex=0). Data fields retain their previous value and are don't-care.
  2. hazard=1: load the bubble. IF/ID holds, so instr_id is re-presented next cycle. With the load now in MEM, hazard clears and fwdunit forwards from WB.
  3. Otherwise: capture all *_id inputs, with valid_ex=valid_id.
  4. valid_id=0 with no flush or hazard: capture the inputs, with valid_ex=0 and instr_ex=NOP forced.
- Latency: 1 cycle from ID inputs to EX outputs. A load-use dependency costs exactly 1 bubble.
- Simultaneous flush and hazard: flush wins and no stall is raised, because the ID instruction is wrong-path.
- stall_cnt: increments by 1 on each edge where stall_id=1 and saturates at 2^CNT_W-1 with no wrap. It is cleared only by reset.
- Reset mid-stall: all state clears immediately and the stall outputs drop in the same cycle.
- rd_ex==x0 never causes a stall, whatever the rs fields contain.
- The block holds no data forwarding; fwdunit owns forwarding.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode-key constants: OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_R, OP_I;
  - the NOP constant;
  - functions get_rd, get_rs1, get_rs2, uses_rs1, uses_rs2.
- One sub-module, hazard_detect: purely combinational, taking instr_id, valid_id, instr_ex, valid_ex and flush and producing hazard and stall. It is reused by the formal harness.
- Register and counter logic stays in id_ex_stage.

Test Plan:
- Reset check: assert rst_n=0 mid-stream, between clock edges -> instr_ex=32'h00000013, valid_ex=0, stall_cnt=0 immediately.
- Load-use on rs1: lw x5,0(x1) (32'h0000A283), then add x6,x5,x1 (32'h00128333) -> one cycle with stall_if=stall_id=1, one NOP bubble, add reaches EX one cycle late, stall_cnt=1.
- Load-use on rs2: lw x5 (32'h0000A283), then sw x5,0(x2) (32'h00512023) -> stall for 1 cycle. With lui x6,0x28 (32'h00028337, rs1 field=5) after the load instead -> no stall.
- No stall on x0: lw x0,0(x1) (32'h0000A003), then add x6,x0,x1 (32'h00100333) -> stall_id stays 0 and the add follows back-to-back.
- Flush beats hazard: hazard pair as in the rs1 case, with flush=1 in the hazard cycle -> stall_id=0, bubble inserted, stall_cnt unchanged.
- Saturation: CNT_W=2 with 5 consecutive load-use pairs -> stall_cnt reads 1,2,3,3,3.
